// File: rtl/lock_passage_scheduler.sv
// lock_passage_scheduler
//
// Sequencer for the canal lock chamber. Arrival requests come from the
// outer (level 0) side and departure requests from the inner (LEVEL_MAX)
// side. Both are queued in small saturating counters. The two directions
// are served round-robin, one complete passage at a time. A passage
// brings the water to the start level, opens the entry gate, moves the
// water to the far level, opens the exit gate and then acknowledges.
//
// Ports
//   clk              system clock, all state on the rising edge
//   reset            asynchronous, active-low reset
//   arr_req          arrival request, one counted per cycle sampled high
//   dept_req         departure request, one counted per cycle sampled high
//   outer_gate_open  outer gate commanded open
//   inner_gate_open  inner gate commanded open
//   inc_water_level  one-cycle pulse per level step up
//   dec_water_level  one-cycle pulse per level step down
//   water_level      level counter, 0..LEVEL_MAX
//   arr_pending      queued arrivals
//   dept_pending     queued departures
//   arr_ack          one-cycle pulse, arrival passage complete
//   dept_ack         one-cycle pulse, departure passage complete
//   busy             high whenever a passage is in progress
//   ovf              sticky, a request arrived at a full counter
//
// All outputs are registered. They change on the same edge that enters
// the state they describe, so a level step and its inc/dec pulse appear
// together.

module lock_passage_scheduler #(
    parameter int LEVEL_MAX = 8,
    parameter int GATE_TIME = 4,
    parameter int QMAX      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arr_req,
    input  logic       dept_req,
    output logic       outer_gate_open,
    output logic       inner_gate_open,
    output logic       inc_water_level,
    output logic       dec_water_level,
    output logic [3:0] water_level,
    output logic [1:0] arr_pending,
    output logic [1:0] dept_pending,
    output logic       arr_ack,
    output logic       dept_ack,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADJUST,
        S_OPEN1,
        S_MOVE,
        S_OPEN2,
        S_DONE
    } state_t;

    typedef enum logic {
        DIR_ARR,
        DIR_DEPT
    } dir_t;

    localparam int              CNT_MAX   = (GATE_TIME > LEVEL_MAX) ? GATE_TIME : LEVEL_MAX;
    localparam int              CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [3:0]      LVL_TOP   = 4'(LEVEL_MAX);
    localparam logic [1:0]      Q_TOP     = 2'(QMAX);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_TIME - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(LEVEL_MAX - 1);

    state_t           state;
    dir_t             dir;
    dir_t             last_served;
    logic [CNT_W-1:0] cnt;

    dir_t             pick_dir;
    logic [3:0]       pick_start;
    logic [3:0]       cur_start;
    logic [3:0]       cur_end;
    logic             take_arr;
    logic             take_dept;

    // Saturating pending counter. A request and a completion in the same
    // cycle cancel, so a request that coincides with a freed slot is kept
    // even when the counter is full.
    function automatic logic [1:0] next_pending(input logic [1:0] cur,
                                                input logic       req,
                                                input logic       take);
        logic [1:0] nxt;
        nxt = cur;
        if (take && !req && cur != 2'd0) begin
            nxt = cur - 2'd1;
        end else if (req && !take && cur != Q_TOP) begin
            nxt = cur + 2'd1;
        end
        return nxt;
    endfunction

    function automatic logic pending_overflow(input logic [1:0] cur,
                                              input logic       req,
                                              input logic       take);
        return req && !take && (cur == Q_TOP);
    endfunction

    function automatic logic [3:0] level_at_start(input dir_t d);
        return (d == DIR_ARR) ? 4'd0 : LVL_TOP;
    endfunction

    function automatic logic [3:0] level_at_end(input dir_t d);
        return (d == DIR_ARR) ? LVL_TOP : 4'd0;
    endfunction

    function automatic logic [3:0] step_level(input logic [3:0] cur,
                                              input logic [3:0] target);
        return (target > cur) ? cur + 4'd1 : cur - 4'd1;
    endfunction

    // Round-robin choice: with both queues non-empty, the side not served
    // last goes next; otherwise the only non-empty side wins.
    always_comb begin
        pick_dir = DIR_ARR;
        if (arr_pending != 2'd0 && dept_pending != 2'd0) begin
            pick_dir = (last_served == DIR_DEPT) ? DIR_ARR : DIR_DEPT;
        end else if (arr_pending == 2'd0) begin
            pick_dir = DIR_DEPT;
        end
        pick_start = level_at_start(pick_dir);
        cur_start  = level_at_start(dir);
        cur_end    = level_at_end(dir);
        take_arr   = (state == S_DONE) && (dir == DIR_ARR);
        take_dept  = (state == S_DONE) && (dir == DIR_DEPT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            dir             <= DIR_ARR;
            last_served     <= DIR_DEPT;
            cnt             <= '0;
            outer_gate_open <= 1'b0;
            inner_gate_open <= 1'b0;
            inc_water_level <= 1'b0;
            dec_water_level <= 1'b0;
            water_level     <= 4'd0;
            arr_pending     <= 2'd0;
            dept_pending    <= 2'd0;
            arr_ack         <= 1'b0;
            dept_ack        <= 1'b0;
            busy            <= 1'b0;
            ovf             <= 1'b0;
        end else begin
            // Request queues run independently of the passage sequence.
            arr_pending  <= next_pending(arr_pending, arr_req, take_arr);
            dept_pending <= next_pending(dept_pending, dept_req, take_dept);
            ovf          <= ovf
                            | pending_overflow(arr_pending, arr_req, take_arr)
                            | pending_overflow(dept_pending, dept_req, take_dept);

            inc_water_level <= 1'b0;
            dec_water_level <= 1'b0;
            arr_ack         <= 1'b0;
            dept_ack        <= 1'b0;

            case (state)
                // Choose a direction and decide whether the level must be
                // brought to the start side first.
                S_IDLE: begin
                    if (arr_pending != 2'd0 || dept_pending != 2'd0) begin
                        dir         <= pick_dir;
                        last_served <= pick_dir;
                        busy        <= 1'b1;
                        if (water_level == pick_start) begin
                            state           <= S_OPEN1;
                            outer_gate_open <= (pick_dir == DIR_ARR);
                            inner_gate_open <= (pick_dir == DIR_DEPT);
                            cnt             <= GATE_LAST;
                        end else begin
                            // The first adjust step is taken on the way in.
                            state           <= S_ADJUST;
                            water_level     <= step_level(water_level, pick_start);
                            inc_water_level <= (pick_start > water_level);
                            dec_water_level <= (pick_start < water_level);
                        end
                    end
                end

                // One step per cycle until the start level is reached.
                S_ADJUST: begin
                    if (water_level == cur_start) begin
                        state           <= S_OPEN1;
                        outer_gate_open <= (dir == DIR_ARR);
                        inner_gate_open <= (dir == DIR_DEPT);
                        cnt             <= GATE_LAST;
                    end else begin
                        water_level     <= step_level(water_level, cur_start);
                        inc_water_level <= (cur_start > water_level);
                        dec_water_level <= (cur_start < water_level);
                    end
                end

                // Entry gate held open; the gate closes on the same edge as
                // the first move step.
                S_OPEN1: begin
                    if (cnt == '0) begin
                        state           <= S_MOVE;
                        outer_gate_open <= 1'b0;
                        inner_gate_open <= 1'b0;
                        water_level     <= step_level(water_level, cur_end);
                        inc_water_level <= (dir == DIR_ARR);
                        dec_water_level <= (dir == DIR_DEPT);
                        cnt             <= MOVE_LAST;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // LEVEL_MAX steps toward the far side.
                S_MOVE: begin
                    if (cnt == '0) begin
                        state           <= S_OPEN2;
                        outer_gate_open <= (dir == DIR_DEPT);
                        inner_gate_open <= (dir == DIR_ARR);
                        cnt             <= GATE_LAST;
                    end else begin
                        water_level     <= step_level(water_level, cur_end);
                        inc_water_level <= (dir == DIR_ARR);
                        dec_water_level <= (dir == DIR_DEPT);
                        cnt             <= cnt - 1'b1;
                    end
                end

                // Exit gate held open.
                S_OPEN2: begin
                    if (cnt == '0) begin
                        state           <= S_DONE;
                        outer_gate_open <= 1'b0;
                        inner_gate_open <= 1'b0;
                        arr_ack         <= (dir == DIR_ARR);
                        dept_ack        <= (dir == DIR_DEPT);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // Acknowledge cycle; the served counter drops on leaving.
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state           <= S_IDLE;
                    busy            <= 1'b0;
                    outer_gate_open <= 1'b0;
                    inner_gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_passage_scheduler.sv
module tb_lock_passage_scheduler;

    localparam int LEVEL_MAX = 8;
    localparam int GATE_TIME = 4;
    localparam int QMAX      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arr_req = 1'b0;
    logic       dept_req = 1'b0;
    logic       outer_gate_open, inner_gate_open;
    logic       inc_water_level, dec_water_level;
    logic [3:0] water_level;
    logic [1:0] arr_pending, dept_pending;
    logic       arr_ack, dept_ack, busy, ovf;

    lock_passage_scheduler #(
        .LEVEL_MAX(LEVEL_MAX),
        .GATE_TIME(GATE_TIME),
        .QMAX(QMAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .arr_req(arr_req),
        .dept_req(dept_req),
        .outer_gate_open(outer_gate_open),
        .inner_gate_open(inner_gate_open),
        .inc_water_level(inc_water_level),
        .dec_water_level(dec_water_level),
        .water_level(water_level),
        .arr_pending(arr_pending),
        .dept_pending(dept_pending),
        .arr_ack(arr_ack),
        .dept_ack(dept_ack),
        .busy(busy),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       outer;
        logic       inner;
        logic       inc;
        logic       dec;
        logic [3:0] lvl;
        logic       aack;
        logic       dack;
        logic       busy;
    } frame_t;

    frame_t dut_f;
    assign dut_f = {outer_gate_open, inner_gate_open, inc_water_level, dec_water_level,
                    water_level, arr_ack, dept_ack, busy};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a passage is expanded into a list of per-cycle
    // output frames the moment it is scheduled; queues are plain counts.
    frame_t q[$];
    frame_t cur;
    int     m_arr, m_dept, m_last;
    bit     m_ovf;

    task automatic model_reset();
        q.delete();
        cur    = '0;
        m_arr  = 0;
        m_dept = 0;
        m_ovf  = 0;
        m_last = 1;
    endtask

    task automatic push(input int lvl, input bit outer, input bit inner, input bit inc,
                        input bit dec, input bit aack, input bit dack);
        frame_t f;
        f       = '0;
        f.lvl   = 4'(lvl);
        f.outer = outer;
        f.inner = inner;
        f.inc   = inc;
        f.dec   = dec;
        f.aack  = aack;
        f.dack  = dack;
        f.busy  = 1'b1;
        q.push_back(f);
    endtask

    task automatic build_plan(input int d, input int lvl);
        int start, L;
        start = (d == 0) ? 0 : LEVEL_MAX;
        L = lvl;
        while (L != start) begin
            if (start > L) begin L++; push(L, 0, 0, 1, 0, 0, 0); end
            else           begin L--; push(L, 0, 0, 0, 1, 0, 0); end
        end
        for (int i = 0; i < GATE_TIME; i++) push(L, d == 0, d == 1, 0, 0, 0, 0);
        for (int i = 0; i < LEVEL_MAX; i++) begin
            L = (d == 0) ? L + 1 : L - 1;
            push(L, 0, 0, d == 0, d == 1, 0, 0);
        end
        for (int i = 0; i < GATE_TIME; i++) push(L, d == 1, d == 0, 0, 0, 0, 0);
        push(L, 0, 0, 0, 0, d == 0, d == 1);
    endtask

    task automatic model_step(input bit a, input bit d);
        int na, nd, pick;
        bit take_a, take_d;
        frame_t idle_f;
        if (!reset) begin
            model_reset();
            return;
        end
        take_a = cur.aack;
        take_d = cur.dack;
        na = m_arr - (take_a ? 1 : 0);
        nd = m_dept - (take_d ? 1 : 0);
        if (a) begin
            if (take_a || m_arr < QMAX) na++;
            else m_ovf = 1;
        end
        if (d) begin
            if (take_d || m_dept < QMAX) nd++;
            else m_ovf = 1;
        end
        if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (!cur.busy && (m_arr > 0 || m_dept > 0)) begin
            if (m_arr > 0 && m_dept > 0) pick = (m_last == 1) ? 0 : 1;
            else pick = (m_arr > 0) ? 0 : 1;
            m_last = pick;
            build_plan(pick, int'(cur.lvl));
            cur = q.pop_front();
        end else begin
            idle_f     = '0;
            idle_f.lvl = cur.lvl;
            cur        = idle_f;
        end
        m_arr  = na;
        m_dept = nd;
    endtask

    // One clock: model advances with the DUT, outputs compared on the
    // falling edge.
    task automatic cycle();
        logic [1:0] ma, md;
        @(posedge clk);
        model_step(arr_req, dept_req);
        @(negedge clk);
        ma = 2'(m_arr);
        md = 2'(m_dept);
        check("model", {16'd0, dut_f, arr_pending, dept_pending, ovf},
                       {16'd0, cur, ma, md, m_ovf});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) cycle();
        reset = 1'b1;
    endtask

    typedef struct {
        bit arr;
        bit dept;
        int exp_busy;
        int exp_inc;
        int exp_dec;
        int exp_lvl;
        int exp_first;   // 1 = arrival acknowledged first, 2 = departure
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, inc_cnt, dec_cnt, first, acks;
        bit done;
        frame_t ef;
        logic [1:0] ep;

        // Applied in order without reset; each row starts where the
        // previous left the water level (first row starts at 8).
        tbl[0] = '{arr:0, dept:1, exp_busy:17, exp_inc:0, exp_dec:8, exp_lvl:0, exp_first:2};
        tbl[1] = '{arr:0, dept:1, exp_busy:25, exp_inc:8, exp_dec:8, exp_lvl:0, exp_first:2};
        tbl[2] = '{arr:1, dept:1, exp_busy:34, exp_inc:8, exp_dec:8, exp_lvl:0, exp_first:1};
        tbl[3] = '{arr:1, dept:0, exp_busy:17, exp_inc:8, exp_dec:0, exp_lvl:8, exp_first:1};
        tbl[4] = '{arr:1, dept:0, exp_busy:25, exp_inc:8, exp_dec:8, exp_lvl:8, exp_first:1};
        tbl[5] = '{arr:1, dept:1, exp_busy:34, exp_inc:8, exp_dec:8, exp_lvl:8, exp_first:2};

        // Reset state and the exact arrival timeline from level 0.
        do_reset();
        check("reset_outputs", {16'd0, dut_f, arr_pending, dept_pending, ovf}, 32'd0);
        arr_req = 1'b1;
        cycle();
        arr_req = 1'b0;
        check("lat_k0", {22'd0, busy, arr_pending}, {22'd0, 1'b0, 2'd1});
        for (int k = 1; k <= 18; k++) begin
            cycle();
            ef       = '0;
            ef.outer = (k >= 1 && k <= 4);
            ef.inc   = (k >= 5 && k <= 12);
            ef.inner = (k >= 13 && k <= 16);
            ef.aack  = (k == 17);
            ef.busy  = (k >= 1 && k <= 17);
            ef.lvl   = (k < 5) ? 4'd0 : (k <= 12) ? 4'(k - 4) : 4'd8;
            ep       = (k <= 17) ? 2'd1 : 2'd0;
            check($sformatf("lat_k%0d", k), {16'd0, dut_f, arr_pending}, {16'd0, ef, ep});
        end

        // Table of single-pulse passages.
        foreach (tbl[i]) begin
            busy_cnt = 0; inc_cnt = 0; dec_cnt = 0; first = 0; done = 0;
            arr_req  = tbl[i].arr;
            dept_req = tbl[i].dept;
            cycle();
            arr_req  = 1'b0;
            dept_req = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                cycle();
                busy_cnt += int'(busy);
                inc_cnt  += int'(inc_water_level);
                dec_cnt  += int'(dec_water_level);
                if (first == 0 && arr_ack)  first = 1;
                if (first == 0 && dept_ack) first = 2;
                if (busy_cnt > 0 && !busy && arr_pending == 2'd0 && dept_pending == 2'd0) done = 1;
            end
            check($sformatf("tbl%0d_done", i), 32'(done), 32'd1);
            check($sformatf("tbl%0d_busy", i), busy_cnt, tbl[i].exp_busy);
            check($sformatf("tbl%0d_inc", i), inc_cnt, tbl[i].exp_inc);
            check($sformatf("tbl%0d_dec", i), dec_cnt, tbl[i].exp_dec);
            check($sformatf("tbl%0d_level", i), 32'(water_level), tbl[i].exp_lvl);
            check($sformatf("tbl%0d_first_ack", i), first, tbl[i].exp_first);
        end

        // Saturation: five cycles of arr_req while idle at level 0.
        do_reset();
        busy_cnt = 0; inc_cnt = 0; dec_cnt = 0; acks = 0;
        arr_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            busy_cnt += int'(busy);
        end
        arr_req = 1'b0;
        check("sat_pending", 32'(arr_pending), 32'd3);
        check("sat_ovf", 32'(ovf), 32'd1);
        for (int c = 0; c < 300 && acks < 3; c++) begin
            cycle();
            busy_cnt += int'(busy);
            inc_cnt  += int'(inc_water_level);
            dec_cnt  += int'(dec_water_level);
            acks     += int'(arr_ack);
        end
        check("sat_acks", acks, 3);
        check("sat_busy", busy_cnt, 67);
        check("sat_inc", inc_cnt, 24);
        check("sat_dec", dec_cnt, 16);
        cycle();
        check("sat_drained", {29'd0, arr_pending, busy}, 32'd0);
        check("sat_ovf_sticky", 32'(ovf), 32'd1);

        // Reset in the middle of MOVE at level 5, with a departure queued.
        do_reset();
        arr_req = 1'b1;
        cycle();
        arr_req  = 1'b0;
        dept_req = 1'b1;
        cycle();
        dept_req = 1'b0;
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            cycle();
            if (inc_water_level && water_level == 4'd5) done = 1;
        end
        check("mid_reached", 32'(done), 32'd1);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("mid_async_clear", {16'd0, dut_f, arr_pending, dept_pending, ovf}, 32'd0);
        @(negedge clk);
        cycle();
        reset = 1'b1;
        repeat (5) cycle();
        check("mid_after_release", {23'd0, busy, water_level, arr_pending, dept_pending}, 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            arr_req  = ($urandom_range(0, 11) == 0);
            dept_req = ($urandom_range(0, 11) == 0);
            cycle();
        end
        arr_req  = 1'b0;
        dept_req = 1'b0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_passage_scheduler.md
Name: lock_passage_scheduler

Overview:
Sequencer for the canal lock chamber. Queues gondola arrival requests from the outer (low, level 0) side and departure requests from the inner (high, level LEVEL_MAX) side. Arbitrates between them round-robin and drives the gate-open and water-level step controls for one complete passage at a time. Sits between the board switches and the lock datapath (gate LEDs, water-level inc/dec).

Parameters:
LEVEL_MAX, 8, water-level steps between outer (0) and inner (LEVEL_MAX) level; internal level counter is 4 bits.
GATE_TIME, 4, cycles a gate is held open per passage phase (minimum 1).
QMAX, 3, saturation value of each pending-request counter (2-bit counters).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
arr_req  in  1  arrival request; one request counted per cycle sampled high
dept_req  in  1  departure request; one request counted per cycle sampled high
outer_gate_open  out  1  outer gate commanded open
inner_gate_open  out  1  inner gate commanded open
inc_water_level  out  1  one-cycle pulse per level step up
dec_water_level  out  1  one-cycle pulse per level step down
water_level  out  4  internal level counter, 0..LEVEL_MAX
arr_pending  out  2  queued arrivals
dept_pending  out  2  queued departures
arr_ack  out  1  one-cycle pulse, arrival passage complete
dept_ack  out  1  one-cycle pulse, departure passage complete
busy  out  1  high in any state other than IDLE
ovf  out  1  sticky; set when a request arrives at a counter already at QMAX

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, water_level=0, pending counters=0, all outputs 0, last_served=DEPT (arrival wins first tie).
- Pending counters: +1 on req; -1 in the DONE cycle for the served direction; both in the same cycle leaves the counter unchanged. At QMAX a req is dropped and ovf is set. ovf clears only on reset.
- IDLE: if exactly one counter is nonzero, serve that direction. If both are nonzero, serve the direction opposite last_served. Latch dir and update last_served on the transition. If water_level equals the start level (arrival 0, departure LEVEL_MAX), next state is OPEN1; otherwise next state is ADJUST.
- ADJUST: step water_level one per cycle toward the start level. Pulse inc or dec in each stepping cycle. Enter OPEN1 on the cycle after the level reaches the start level.
- OPEN1: assert the entry gate (outer for arrival, inner for departure) for exactly GATE_TIME cycles, then go to MOVE.
- MOVE: step toward the end level (arrival LEVEL_MAX, departure 0) for exactly LEVEL_MAX cycles, one inc/dec pulse per cycle, then go to OPEN2.
- OPEN2: assert the exit gate for GATE_TIME cycles, then go to DONE.
- DONE: one cycle. Assert arr_ack or dept_ack and decrement the matching counter. Next state is IDLE.
- Invariants:
  - Never both gates open at once.
  - inc and dec are never high together.
  - No level step while either gate is open.
  - water_level never leaves 0..LEVEL_MAX.
- Requests arriving while busy only queue; they never preempt a passage in progress.
- Reset mid-passage: all outputs drop immediately to 0, the level returns to 0, and queued requests are lost.
- Default latency, arrival from level 0: pending becomes 1 at edge N. outer_gate_open is high cycles N+1..N+4. inc is high N+5..N+12. inner_gate_open is high N+13..N+16. arr_ack is high at N+17. busy is high N+1..N+17.

Test Plan:
1. Reset, one arr_req pulse -> outer_gate_open 4 cycles, 8 inc pulses, water_level ends at 8, inner_gate_open 4 cycles, arr_ack 1 cycle, arr_pending 1->0.
2. After test 1 (level 8), one dept_req -> no ADJUST; inner gate 4 cycles, 8 dec pulses to level 0, outer gate 4 cycles, dept_ack.
3. At level 0, one dept_req -> ADJUST gives 8 inc pulses before inner_gate_open rises; total busy 25 cycles.
4. arr_req and dept_req pulsed in the same cycle after reset -> arrival served first, then departure with no ADJUST; acks in order arr, dept; both pending counters end at 0.
5. Hold arr_req high 5 cycles while idle -> arr_pending saturates at 3 and ovf=1. Three back-to-back arrival passages follow, each preceded by an 8-step ADJUST down except the first.
6. Assert reset low during MOVE at level 5 -> gates, inc/dec, busy and water_level are 0 without waiting for a clock; after release the block stays IDLE with pending counters at 0.
